// File: rtl/vga_line_prefetch_if.sv
// rtl/vga_line_prefetch_if.sv - frame-memory burst read port between line prefetcher and memory
interface vga_line_prefetch_if #(
    parameter int ADDR_W = 20
) ();
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic              mem_rd_valid;
    logic [15:0]       mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_ack,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_ack,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/vga_line_prefetch.sv
// rtl/vga_line_prefetch.sv - ping-pong line prefetcher feeding the VGA pixel pipeline
module vga_line_prefetch #(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int BURST       = 32,
    parameter int ADDR_W      = 20,
    parameter int FB_BASE     = 0,
    parameter int LINE_STRIDE = 640
) (
    input  logic                vga_clk,
    input  logic                sys_rst_n,
    input  logic                vga_vs,
    input  logic                data_req,
    output logic [15:0]         pixel_data,
    output logic                underrun,
    output logic                fetch_busy,
    vga_line_prefetch_if.master mem
);
    localparam int PTR_W  = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int LINE_W = $clog2(V_DISP + 1);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(LINE_STRIDE);
    localparam logic [ADDR_W-1:0] BSTEP     = ADDR_W'(BURST);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(H_DISP - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [LINE_W-1:0] LINES     = LINE_W'(V_DISP);

    typedef enum logic [1:0] {IDLE, REQ, BEATS, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       line_buf [2][H_DISP];
    logic [1:0]        buf_full;
    logic [1:0]        full_nxt;
    logic              wbuf;
    logic              dbuf;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [BEAT_W-1:0] beat_cnt;
    logic [LINE_W-1:0] fetch_line;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              data_req_d;

    logic beat_in;
    logic burst_done;
    logic line_done;
    logic start_line;
    logic fill;
    logic line_end;

    // Beats are counted in DRAIN too so the discarded tail of an aborted burst is tracked exactly.
    assign beat_in    = mem.mem_rd_valid && (state == BEATS || state == DRAIN);
    assign burst_done = beat_in && (beat_cnt == BEAT_LAST);
    assign line_done  = burst_done && (wr_ptr == PTR_LAST);
    assign start_line = (state == IDLE) && vga_vs && (fetch_line < LINES) && !buf_full[wbuf];
    assign fill       = (state == BEATS) && line_done && vga_vs;
    assign line_end   = data_req_d && !data_req;

    assign mem.mem_rd_req  = (state == REQ) && vga_vs;
    assign mem.mem_rd_addr = rd_addr;
    assign fetch_busy      = (state != IDLE);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_line) state_nxt = REQ;
            end
            REQ: begin
                if (!vga_vs)               state_nxt = IDLE;
                else if (mem.mem_rd_ack)   state_nxt = BEATS;
            end
            BEATS: begin
                if (burst_done)            state_nxt = (line_done || !vga_vs) ? IDLE : REQ;
                else if (!vga_vs)          state_nxt = DRAIN;
            end
            DRAIN: begin
                if (burst_done)            state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A fill landing on the buffer the display is releasing keeps it full.
    always_comb begin
        full_nxt = buf_full;
        if (line_end) full_nxt[dbuf] = 1'b0;
        if (fill)     full_nxt[wbuf] = 1'b1;
        if (!vga_vs)  full_nxt       = 2'b00;
    end

    always_ff @(posedge vga_clk) begin
        if (state == BEATS && mem.mem_rd_valid && vga_vs) begin
            line_buf[wbuf][wr_ptr] <= mem.mem_rd_data;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            buf_full   <= 2'b00;
            wbuf       <= 1'b0;
            dbuf       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            fetch_line <= '0;
            line_addr  <= BASE;
            rd_addr    <= '0;
            data_req_d <= 1'b0;
            pixel_data <= 16'h0000;
            underrun   <= 1'b0;
        end else begin
            buf_full   <= full_nxt;
            data_req_d <= data_req;

            if (start_line) begin
                rd_addr  <= line_addr;
                wr_ptr   <= '0;
                beat_cnt <= '0;
            end
            if (beat_in) begin
                beat_cnt <= burst_done ? '0 : beat_cnt + 1'b1;
            end
            if (state == BEATS && mem.mem_rd_valid && vga_vs) begin
                wr_ptr <= line_done ? '0 : wr_ptr + 1'b1;
            end
            if (state == BEATS && burst_done && vga_vs && !line_done) begin
                rd_addr <= rd_addr + BSTEP;
            end

            if (data_req && buf_full[dbuf]) begin
                pixel_data <= line_buf[dbuf][rd_ptr];
            end else begin
                pixel_data <= 16'h0000;
            end

            if (!vga_vs) begin
                wbuf       <= 1'b0;
                dbuf       <= 1'b0;
                rd_ptr     <= '0;
                fetch_line <= '0;
                line_addr  <= BASE;
                underrun   <= 1'b0;
            end else begin
                if (fill) begin
                    wbuf       <= ~wbuf;
                    fetch_line <= fetch_line + 1'b1;
                    line_addr  <= line_addr + STRIDE;
                end
                if (line_end) begin
                    dbuf   <= ~dbuf;
                    rd_ptr <= '0;
                end else if (data_req && rd_ptr != PTR_LAST) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (data_req && !buf_full[dbuf]) begin
                    underrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb/tb_vga_line_prefetch.sv - scoreboard bench for vga_line_prefetch with a burst memory model
module tb_vga_line_prefetch;
    localparam int H_DISP      = 64;
    localparam int V_DISP      = 6;
    localparam int BURST       = 16;
    localparam int ADDR_W      = 20;
    localparam int FB_BASE     = 32'hFFFE0;
    localparam int LINE_STRIDE = 80;
    localparam int H_TOTAL     = 96;
    localparam int BPL         = H_DISP / BURST;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic        vga_vs;
    logic        data_req;
    logic [15:0] pixel_data;
    logic        underrun;
    logic        fetch_busy;

    vga_line_prefetch_if #(.ADDR_W(ADDR_W)) mem_if ();

    vga_line_prefetch #(
        .H_DISP(H_DISP), .V_DISP(V_DISP), .BURST(BURST), .ADDR_W(ADDR_W),
        .FB_BASE(FB_BASE), .LINE_STRIDE(LINE_STRIDE)
    ) dut (
        .vga_clk(vga_clk),
        .sys_rst_n(sys_rst_n),
        .vga_vs(vga_vs),
        .data_req(data_req),
        .pixel_data(pixel_data),
        .underrun(underrun),
        .fetch_busy(fetch_busy),
        .mem(mem_if)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic        chk;
        logic [15:0] val;
    } pix_t;

    typedef struct {
        string name;
        int    ack_delay;
        int    valid_every;
        int    back_porch;
        int    line0_mode;
        int    other_mode;
        int    exp_acc;
        logic  exp_underrun;
    } frame_vec_t;

    int checks = 0;
    int errors = 0;
    pix_t pix_q[$];

    int ack_delay = 0;
    int valid_every = 1;
    bit ack_block = 1'b0;
    int beats_left = 0;
    int beats_done = 0;
    int vcnt = 0;
    int ack_wait = 0;
    int n_acc = 0;
    logic [ADDR_W-1:0] beat_addr = '0;
    logic s_req, s_ack, s_dreq;
    logic [ADDR_W-1:0] s_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_req_addr(input int idx);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(FB_BASE + (idx / BPL) * LINE_STRIDE + (idx % BPL) * BURST);
        return a;
    endfunction

    function automatic logic [15:0] exp_pix(input int line, input int i);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(FB_BASE + line * LINE_STRIDE + i);
        return a[15:0];
    endfunction

    task automatic tick();
        pix_t e;
        #2;
        s_req  = mem_if.mem_rd_req;
        s_ack  = mem_if.mem_rd_ack;
        s_addr = mem_if.mem_rd_addr;
        s_dreq = data_req;
        @(posedge vga_clk);
        #1;
        if (s_req && s_ack) begin
            check("one_outstanding", beats_left, 0);
            check("req_addr", 32'(s_addr), 32'(exp_req_addr(n_acc)));
            n_acc++;
            beats_left = BURST;
            beats_done = 0;
            beat_addr  = s_addr;
            vcnt       = 0;
            ack_wait   = 0;
        end
        if (s_dreq) begin
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_queue: empty when pixel 0x%0h returned", pixel_data);
            end else begin
                e = pix_q.pop_front();
                if (e.chk) check("pixel", pixel_data, e.val);
            end
        end else begin
            check("pixel_idle", pixel_data, 0);
        end
        mem_if.mem_rd_valid = 1'b0;
        if (beats_left > 0) begin
            vcnt++;
            if (vcnt >= valid_every) begin
                vcnt = 0;
                mem_if.mem_rd_valid = 1'b1;
                mem_if.mem_rd_data  = beat_addr[15:0];
                beat_addr++;
                beats_left--;
                beats_done++;
            end
        end
        if (mem_if.mem_rd_req && !ack_block) begin
            if (ack_wait >= ack_delay) mem_if.mem_rd_ack = 1'b1;
            else begin
                ack_wait++;
                mem_if.mem_rd_ack = 1'b0;
            end
        end else begin
            mem_if.mem_rd_ack = 1'b0;
            if (!mem_if.mem_rd_req) ack_wait = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) tick();
    endtask

    // mode 0: expect frame data, 1: expect zero pixels, 2: unchecked
    task automatic run_line(input int line, input int mode);
        pix_t e;
        for (int i = 0; i < H_TOTAL; i++) begin
            data_req = (i < H_DISP);
            if (data_req) begin
                e.chk = (mode != 2);
                e.val = (mode == 1) ? 16'h0000 : exp_pix(line, i);
                pix_q.push_back(e);
            end
            tick();
        end
        data_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t vecs[3];
        int w;
        logic [ADDR_W-1:0] hold_addr;

        vecs[0] = '{"fast",  0, 1, 2*H_TOTAL, 0, 0, V_DISP*BPL, 1'b0};
        vecs[1] = '{"slow",  5, 2, 0,         1, 2, -1,         1'b1};
        vecs[2] = '{"delay", 2, 1, 2*H_TOTAL, 0, 0, V_DISP*BPL, 1'b0};

        sys_rst_n = 1'b0;
        vga_vs    = 1'b0;
        data_req  = 1'b0;
        mem_if.mem_rd_ack   = 1'b0;
        mem_if.mem_rd_valid = 1'b0;
        mem_if.mem_rd_data  = 16'h0000;
        repeat (3) @(posedge vga_clk);
        #1;
        check("rst_pixel", pixel_data, 0);
        check("rst_req", mem_if.mem_rd_req, 0);
        check("rst_addr", 32'(mem_if.mem_rd_addr), 0);
        check("rst_underrun", underrun, 0);
        check("rst_busy", fetch_busy, 0);
        sys_rst_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            ack_delay   = vecs[v].ack_delay;
            valid_every = vecs[v].valid_every;
            vga_vs   = 1'b0;
            data_req = 1'b0;
            n_acc    = 0;
            run_cycles(2);
            check({vecs[v].name, "_underrun_clr"}, underrun, 0);
            run_cycles(2*H_TOTAL - 2);
            check({vecs[v].name, "_vsync_idle"}, fetch_busy, 0);
            check({vecs[v].name, "_vsync_noreq"}, n_acc, 0);
            vga_vs = 1'b1;
            if (vecs[v].back_porch > 0) begin
                run_cycles(vecs[v].back_porch);
                check({vecs[v].name, "_primed"}, n_acc, 2*BPL);
            end
            for (int l = 0; l < V_DISP; l++) begin
                run_line(l, (l == 0) ? vecs[v].line0_mode : vecs[v].other_mode);
                if (l == 0) check({vecs[v].name, "_underrun_line0"}, underrun, (vecs[v].line0_mode == 1));
            end
            run_cycles(4*H_TOTAL);
            check({vecs[v].name, "_underrun_end"}, underrun, vecs[v].exp_underrun);
            if (vecs[v].exp_acc >= 0) begin
                check({vecs[v].name, "_req_count"}, n_acc, vecs[v].exp_acc);
                check({vecs[v].name, "_idle_end"}, fetch_busy, 0);
                check({vecs[v].name, "_no_req_end"}, mem_if.mem_rd_req, 0);
            end
        end

        // Request held without ack must stay stable.
        ack_delay = 0;
        valid_every = 1;
        ack_block = 1'b1;
        vga_vs = 1'b0;
        n_acc = 0;
        run_cycles(80);
        vga_vs = 1'b1;
        w = 0;
        while (!mem_if.mem_rd_req && w < 50) begin
            tick();
            w++;
        end
        check("hold_req_seen", mem_if.mem_rd_req, 1);
        hold_addr = mem_if.mem_rd_addr;
        check("hold_first_addr", 32'(hold_addr), 32'(exp_req_addr(0)));
        for (int c = 0; c < 100; c++) begin
            tick();
            check("hold_req", mem_if.mem_rd_req, 1);
            check("hold_addr", 32'(mem_if.mem_rd_addr), 32'(hold_addr));
        end
        check("hold_no_accept", n_acc, 0);
        ack_block = 1'b0;
        run_cycles(3*H_TOTAL);
        check("hold_prime_count", n_acc, 2*BPL);
        check("hold_idle", fetch_busy, 0);

        // Abort the first burst after 10 beats.
        vga_vs = 1'b0;
        n_acc = 0;
        run_cycles(40);
        vga_vs = 1'b1;
        w = 0;
        while (!(n_acc == 1 && beats_done == 10) && w < 200) begin
            tick();
            w++;
        end
        check("drain_beat10", beats_done, 10);
        vga_vs = 1'b0;
        n_acc = 0;
        run_cycles(3);
        check("drain_busy", fetch_busy, 1);
        check("drain_no_req", mem_if.mem_rd_req, 0);
        vga_vs = 1'b1;
        w = 0;
        while (n_acc == 0 && w < 200) begin
            tick();
            w++;
        end
        check("drain_refetch", n_acc, 1);
        run_cycles(2*H_TOTAL);
        run_line(0, 0);
        run_line(1, 0);
        check("drain_underrun", underrun, 0);
        check("pix_queue_drained", pix_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
